// File: rtl/decoder_7seg.sv
// decoder_7seg: registered three-digit BCD to 7-segment decoder; DECODER_ACTIVE_LOW_SEGS_EN selects common-anode (inverted) segments
module decoder_7seg #(
  parameter logic [6:0] BLANK_PATTERN = 7'h00,
  parameter logic [6:0] ERR_PATTERN   = 7'h40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       blank,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min,
  output logic [6:0] sec_ones_segs,
  output logic [6:0] sec_tens_segs,
  output logic [6:0] min_segs,
  output logic       bcd_err
);
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = ERR_PATTERN;
    endcase
  endfunction

  logic [6:0] so_d, st_d, mi_d, so_q, st_q, mi_q;
  logic       err_d, err_q;

  // decode each digit independently; blank overrides segments but not the error flag
  always_comb begin
    so_d  = blank ? BLANK_PATTERN : seg7(sec_ones);
    st_d  = blank ? BLANK_PATTERN : seg7(sec_tens);
    mi_d  = blank ? BLANK_PATTERN : seg7(min);
    err_d = (sec_ones > 4'd9) | (sec_tens > 4'd9) | (min > 4'd9);
  end

  // one-cycle output register; reset wins over blank and data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      so_q  <= BLANK_PATTERN;
      st_q  <= BLANK_PATTERN;
      mi_q  <= BLANK_PATTERN;
      err_q <= 1'b0;
    end else begin
      so_q  <= so_d;
      st_q  <= st_d;
      mi_q  <= mi_d;
      err_q <= err_d;
    end
  end

`ifdef DECODER_ACTIVE_LOW_SEGS_EN
  assign sec_ones_segs = ~so_q;
  assign sec_tens_segs = ~st_q;
  assign min_segs      = ~mi_q;
`else
  assign sec_ones_segs = so_q;
  assign sec_tens_segs = st_q;
  assign min_segs      = mi_q;
`endif
  assign bcd_err = err_q;
endmodule

// File: tb/tb_decoder_7seg.sv
// tb_decoder_7seg: scoreboard bench for decoder_7seg (also valid with DECODER_ACTIVE_LOW_SEGS_EN)
module tb_decoder_7seg;
  logic       clk = 1'b0;
  logic       rst_n, blank;
  logic [3:0] sec_ones, sec_tens, min;
  logic [6:0] sec_ones_segs, sec_tens_segs, min_segs;
  logic       bcd_err;

  typedef struct {
    logic [6:0] so, st, mi;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic [6:0] enc [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
`ifdef DECODER_ACTIVE_LOW_SEGS_EN
  localparam logic [6:0] INV = 7'h7F;
`else
  localparam logic [6:0] INV = 7'h00;
`endif

  decoder_7seg dut (
    .clk(clk), .rst_n(rst_n), .blank(blank),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min(min),
    .sec_ones_segs(sec_ones_segs), .sec_tens_segs(sec_tens_segs),
    .min_segs(min_segs), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [6:0] a, input logic [6:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, x, $time);
    end
  endtask

  task automatic step(input logic r, input logic b,
                      input logic [3:0] so, input logic [3:0] st, input logic [3:0] mi,
                      input logic [6:0] eso, input logic [6:0] est, input logic [6:0] emi,
                      input logic eerr);
    exp_t e;
    @(negedge clk);
    rst_n = r; blank = b; sec_ones = so; sec_tens = st; min = mi;
    e.so = eso; e.st = est; e.mi = emi; e.err = eerr;
    q.push_back(e);
  endtask

  // monitor: registered outputs are valid every cycle, compare just after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sec_ones_segs", sec_ones_segs, e.so ^ INV);
        chk("sec_tens_segs", sec_tens_segs, e.st ^ INV);
        chk("min_segs", min_segs, e.mi ^ INV);
        chk("bcd_err", {6'd0, bcd_err}, {6'd0, e.err});
      end
    end
  end

  initial begin
    rst_n = 1'b0; blank = 1'b0; sec_ones = 4'd0; sec_tens = 4'd0; min = 4'd0;
    // reset with inputs 1/1/1, then release
    step(0, 0, 1, 1, 1, 7'h00, 7'h00, 7'h00, 0);
    step(0, 0, 1, 1, 1, 7'h00, 7'h00, 7'h00, 0);
    step(1, 0, 1, 1, 1, 7'h06, 7'h06, 7'h06, 0);
    // sweeps, one digit at a time
    for (int i = 0; i < 10; i++) step(1, 0, 4'(i), 0, 0, enc[i], 7'h3F, 7'h3F, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 4'(i), 0, 7'h3F, enc[i], 7'h3F, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 4'(i), 7'h3F, 7'h3F, enc[i], 0);
    // mixed values
    step(1, 0, 1, 0, 1, 7'h06, 7'h3F, 7'h06, 0);
    step(1, 0, 0, 1, 1, 7'h3F, 7'h06, 7'h06, 0);
    step(1, 0, 0, 1, 1, 7'h3F, 7'h06, 7'h06, 0);
    // invalid BCD on each digit
    step(1, 0, 0, 0, 4'hC, 7'h3F, 7'h3F, 7'h40, 1);
    step(1, 0, 0, 0, 3, 7'h3F, 7'h3F, 7'h4F, 0);
    step(1, 0, 4'hA, 5, 3, 7'h40, 7'h6D, 7'h4F, 1);
    step(1, 0, 2, 4'hF, 7, 7'h5B, 7'h40, 7'h07, 1);
    // blank keeps error flag live
    step(1, 1, 9, 5, 9, 7'h00, 7'h00, 7'h00, 0);
    step(1, 1, 9, 5, 4'hB, 7'h00, 7'h00, 7'h00, 1);
    step(1, 0, 9, 5, 9, 7'h6F, 7'h6D, 7'h6F, 0);
    // mid-run reset beats invalid input and blank
    step(0, 0, 9, 5, 9, 7'h00, 7'h00, 7'h00, 0);
    step(0, 1, 4'hE, 5, 9, 7'h00, 7'h00, 7'h00, 0);
    step(1, 0, 8, 8, 8, 7'h7F, 7'h7F, 7'h7F, 0);
    step(1, 0, 6, 2, 4, 7'h7D, 7'h5B, 7'h66, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
